mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter TIMEOUT, 16, memory wait cycles before an access is aborted (legal range 2..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction fetch request, held until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  DATA_W  fetched word, valid while i_ack=1.
REQ-010 d_re, d_we  in  1 each  data read and data write requests (bus_re/bus_we of the datapath), held until d_ack.
REQ-011 d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_be  in  DATA_W/8  data address, write data, byte enables.
REQ-012 d_ack  out  1  one-cycle data completion pulse; d_rdata  out  DATA_W  read word, valid while d_ack=1.
REQ-013 err  out  1  access timed out; valid with i_ack or d_ack.
REQ-014 mem_valid  out  1; mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8  shared memory port.
REQ-015 mem_ready  in  1; mem_rdata  in  DATA_W  memory completion and read data.
REQ-016 stall  out  1  hold request to the control unit.

Function
REQ-017 Three-state FSM SHALL be implemented: IDLE, ACCESS, RESP.
REQ-018 IDLE: a data request is d_re|d_we; if exactly one requester is pending, it SHALL be granted; next state ACCESS.
REQ-019 Both pending in IDLE: the grant SHALL go to the requester not recorded in the last_grant register (round-robin); last_grant SHALL update on every grant.
REQ-020 On grant, addr/wdata/be/we SHALL be registered into the mem_* outputs; mem_we=d_we for data grants, 0 for fetch grants; d_we takes precedence when d_re and d_we are both high.
REQ-021 ACCESS: mem_valid=1 and the mem_* outputs SHALL stay constant until exit.
REQ-022 ACCESS with mem_ready=1: mem_rdata SHALL be latched, err=0, next state RESP.
REQ-023 A wait counter SHALL clear on grant and increment each ACCESS cycle with mem_ready=0.
REQ-024 Reaching TIMEOUT SHALL force the RESP state with err=1 and rdata=0.
REQ-025 RESP: exactly one of i_ack/d_ack (the granted port) SHALL be 1 for one cycle, with registered rdata and err; next state IDLE unconditionally.
REQ-026 Requests SHALL be ignored in ACCESS and RESP; requesters drop or renew req in the cycle after ack; the earliest re-grant is the IDLE cycle following RESP.
REQ-027 Minimum latency: req sampled in IDLE at cycle 0 -> mem_valid at cycle 1 -> mem_ready at cycle 1 -> ack at cycle 2.
REQ-028 i_rdata/d_rdata SHALL hold their last value outside ack cycles; mem_valid=0 in IDLE and RESP.
REQ-029 stall SHALL be combinational: (i_req|d_re|d_we) & ~(i_ack|d_ack).
REQ-030 mem_ready asserted outside ACCESS SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force IDLE; mem_valid, mem_we, i_ack, d_ack and err SHALL be 0, and all data/address registers SHALL be 0.
REQ-032 rst=0 SHALL clear last_grant to DATA, so the first tie after reset grants the fetch port.
REQ-033 rst=0 SHALL clear the wait counter.
REQ-034 Reset during ACCESS SHALL abandon the transaction with no ack issued.

Verification
REQ-035 Fetch alone: i_req=1, i_addr=0x100, mem_ready at cycle 1 with rdata 0x00500093 -> i_ack at cycle 2, i_rdata=0x00500093, err=0.
REQ-036 Tie after reset: i_req and d_re both high -> fetch granted first; data granted on the next IDLE; a later tie goes to the opposite port of the previous grant.
REQ-037 Write: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF, memory 3 wait cycles -> mem_we=1 and fields stable for 4 ACCESS cycles; d_ack one cycle after mem_ready.
REQ-038 Timeout: TIMEOUT=4, mem_ready held 0 -> ack with err=1 and rdata=0 after 4 ACCESS cycles; the next access completes with err=0.
REQ-039 Reset mid-access: rst low in ACCESS -> mem_valid=0 in the same cycle, no ack; after release, a tie grants the fetch port.
REQ-040 stall: check equals 1 from request until the ack cycle, equals 0 in the ack cycle, and equals 0 with no requests.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake and bus signal around the
// instruction/data memory arbiter.
//
// Groups:
//   fetch requester : i_req, i_addr            -> i_ack, i_rdata
//   data requester  : d_re, d_we, d_addr,
//                     d_wdata, d_be            -> d_ack, d_rdata
//   status          : err (timeout, valid with an ack), stall (to control unit)
//   memory port     : mem_valid, mem_addr, mem_we, mem_wdata, mem_be
//                     <- mem_ready, mem_rdata
//
// Modports:
//   master : the arbiter itself (drives acks, status and the memory port)
//   slave  : the surroundings (requesters plus memory)

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  // Data requester
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // Status
  logic              err;
  logic              stall;

  // Shared memory port
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr,
    input  d_re, d_we, d_addr, d_wdata, d_be,
    input  mem_ready, mem_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output err, stall,
    output mem_valid, mem_addr, mem_we, mem_wdata, mem_be
  );

  modport slave (
    output i_req, i_addr,
    output d_re, d_we, d_addr, d_wdata, d_be,
    output mem_ready, mem_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  err, stall,
    input  mem_valid, mem_addr, mem_we, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester (instruction fetch / data) arbiter onto a
// single memory port, with round-robin tie breaking and an access timeout.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_arbiter_if.master (requesters, status and memory port)
//
// Operation: IDLE -> ACCESS -> RESP -> IDLE. A grant in IDLE registers the
// winning request onto the mem_* outputs, which are then held constant for
// the whole ACCESS phase. ACCESS ends on mem_ready or on timeout; the result
// is registered and presented for exactly one RESP cycle on the granted
// port's ack. Minimum request-to-ack latency is two cycles.

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;

  // Last wait-count value before the access is declared dead. The counter
  // holds 0 in the first ACCESS cycle, so TIMEOUT ACCESS cycles elapse.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // Encoding of grant_r / last_grant_r
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t            state_r;
  logic              last_grant_r;
  logic              grant_r;
  logic [7:0]        wait_cnt_r;

  logic              mem_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [BE_W-1:0]   mem_be_r;

  logic              i_ack_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic              d_ack_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              err_r;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic              i_pend_s;
  logic              d_pend_s;
  logic              any_req_s;
  logic              pick_s;
  logic              timeout_s;
  logic              done_s;
  logic [DATA_W-1:0] rsp_data_s;

  assign i_pend_s  = bus.i_req;
  assign d_pend_s  = bus.d_re | bus.d_we;
  assign any_req_s = i_pend_s | d_pend_s;

  // Timeout only counts when memory has not answered in this same cycle,
  // so a late mem_ready on the final allowed cycle still completes cleanly.
  assign timeout_s = ~bus.mem_ready & (wait_cnt_r == TIMEOUT_LAST);
  assign done_s    = bus.mem_ready | timeout_s;

  // Grant selection: single requester wins outright, a tie goes to the port
  // that did not win last time.
  always_comb begin
    pick_s = GRANT_FETCH;
    if (i_pend_s && d_pend_s) begin
      pick_s = ~last_grant_r;
    end else if (d_pend_s) begin
      pick_s = GRANT_DATA;
    end else begin
      pick_s = GRANT_FETCH;
    end
  end

  // Response word: memory data on completion, zero on timeout.
  always_comb begin
    rsp_data_s = '0;
    if (bus.mem_ready) begin
      rsp_data_s = bus.mem_rdata;
    end else begin
      rsp_data_s = '0;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GRANT_DATA;   // first tie after reset goes to fetch
      grant_r      <= GRANT_FETCH;
      wait_cnt_r   <= 8'd0;
      mem_valid_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= '0;
      mem_be_r     <= '0;
      i_ack_r      <= 1'b0;
      i_rdata_r    <= '0;
      d_ack_r      <= 1'b0;
      d_rdata_r    <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          i_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          err_r   <= 1'b0;
          if (any_req_s) begin
            state_r      <= ST_ACCESS;
            grant_r      <= pick_s;
            last_grant_r <= pick_s;
            wait_cnt_r   <= 8'd0;
            mem_valid_r  <= 1'b1;
            if (pick_s == GRANT_DATA) begin
              // A simultaneous read and write request is treated as a write.
              mem_addr_r  <= bus.d_addr;
              mem_we_r    <= bus.d_we;
              mem_wdata_r <= bus.d_wdata;
              mem_be_r    <= bus.d_be;
            end else begin
              // Fetches are full-word reads with no write data.
              mem_addr_r  <= bus.i_addr;
              mem_we_r    <= 1'b0;
              mem_wdata_r <= '0;
              mem_be_r    <= '1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (done_s) begin
            state_r     <= ST_RESP;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            err_r       <= timeout_s;
            if (grant_r == GRANT_DATA) begin
              d_ack_r   <= 1'b1;
              d_rdata_r <= rsp_data_s;
            end else begin
              i_ack_r   <= 1'b1;
              i_rdata_r <= rsp_data_s;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end

        ST_RESP: begin
          // Requests are ignored here; re-arbitration happens in IDLE.
          state_r <= ST_IDLE;
          i_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          err_r   <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          mem_valid_r <= 1'b0;
          mem_we_r    <= 1'b0;
          i_ack_r     <= 1'b0;
          d_ack_r     <= 1'b0;
          err_r       <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------
  assign bus.mem_valid = mem_valid_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_be    = mem_be_r;

  assign bus.i_ack     = i_ack_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.err       = err_r;

  // Control-unit hold: any pending request not being acknowledged this cycle.
  assign bus.stall = (bus.i_req | bus.d_re | bus.d_we) & ~(i_ack_r | d_ack_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Stimulus pushes the expected response
// of every access into a scoreboard queue; an independent monitor pops and
// compares whenever an ack appears. Protocol-level checks (grant order,
// latency, field stability, stall) are made inline by the stimulus.

module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding access.
  always @(negedge clk) begin
    if (rst && (bus.i_ack || bus.d_ack)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack actual=i%0d_d%0d required=none", bus.i_ack, bus.d_ack);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_both_ack", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
        chk("sb_port", {31'd0, bus.d_ack}, {31'd0, mon_e.is_data});
        chk("sb_rdata", mon_e.is_data ? bus.d_rdata : bus.i_rdata, mon_e.rdata);
        chk("sb_err", {31'd0, bus.err}, {31'd0, mon_e.err});
      end
    end
  end

  // One access from grant to the IDLE cycle after its ack. Called at a
  // negedge while the arbiter is in IDLE; the other requester may already be
  // pending and is left untouched.
  task automatic run_xact(input bit is_data, input bit re, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int waits,
                          input logic [31:0] mrd, input bit exp_err);
    exp_t        e;
    int          n_acc;
    logic [31:0] exp_rd;
    begin
      if (is_data) begin
        bus.d_re = re; bus.d_we = we; bus.d_addr = addr;
        bus.d_wdata = wdata; bus.d_be = be;
      end else begin
        bus.i_req = 1'b1; bus.i_addr = addr;
      end
      #1;
      chk("stall_on_req", {31'd0, bus.stall}, 32'd1);
      exp_rd    = exp_err ? 32'd0 : mrd;
      e.is_data = is_data;
      e.rdata   = exp_rd;
      e.err     = exp_err;
      sb_q.push_back(e);
      n_acc = exp_err ? TIMEOUT : waits + 1;
      cyc();
      for (int a = 0; a < n_acc; a++) begin
        chk("acc_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("acc_addr", bus.mem_addr, addr);
        chk("acc_we", {31'd0, bus.mem_we}, {31'd0, is_data & we});
        if (is_data) begin
          chk("acc_wdata", bus.mem_wdata, wdata);
          chk("acc_be", {28'd0, bus.mem_be}, {28'd0, be});
        end
        chk("acc_stall", {31'd0, bus.stall}, 32'd1);
        chk("acc_no_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        bus.mem_ready = (!exp_err && a == n_acc - 1);
        bus.mem_rdata = bus.mem_ready ? mrd : (32'hBAD0_0000 + 32'(a));
        cyc();
      end
      // RESP cycle
      chk("resp_ack", {30'd0, bus.i_ack, bus.d_ack}, is_data ? 32'd1 : 32'd2);
      chk("resp_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("resp_stall", {31'd0, bus.stall}, 32'd0);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hFFFF_FFFF;
      if (is_data) begin
        bus.d_re = 1'b0; bus.d_we = 1'b0;
      end else begin
        bus.i_req = 1'b0;
      end
      cyc();
      // IDLE cycle: ack was a single pulse, read data holds.
      chk("idle_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      chk("idle_rdata_hold", is_data ? bus.d_rdata : bus.i_rdata, exp_rd);
      chk("idle_stall", {31'd0, bus.stall}, {31'd0, bus.i_req | bus.d_re | bus.d_we});
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0;
    bus.d_wdata = 32'd0; bus.d_be = 4'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    cyc(); cyc();

    // Reset state
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b1;

    // Tie after reset: fetch first, then data.
    bus.d_re = 1'b1; bus.d_addr = 32'h0000_3000; bus.d_be = 4'hF;
    run_xact(1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'd0, 4'h0, 0, 32'h1111_1111, 1'b0);
    run_xact(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'hF, 1, 32'h2222_2222, 1'b0);

    // Fetch alone, minimum latency.
    run_xact(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'h0, 0, 32'h0050_0093, 1'b0);

    // Tie after a fetch grant: data wins.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0104;
    run_xact(1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'd0, 4'hF, 0, 32'h3333_3333, 1'b0);
    run_xact(1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'h0, 0, 32'h4444_4444, 1'b0);

    // Write with three wait cycles.
    run_xact(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 3, 32'h5555_5555, 1'b0);

    // Read and write both raised: write wins.
    run_xact(1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, 0, 32'h0000_00AA, 1'b0);

    // mem_ready outside ACCESS is ignored.
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h7777_7777;
    cyc(); cyc();
    chk("stray_ready_no_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("stray_ready_valid", {31'd0, bus.mem_valid}, 32'd0);
    bus.mem_ready = 1'b0;

    // Timeout, then a clean access.
    run_xact(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'hF, 0, 32'h6666_6666, 1'b1);
    run_xact(1'b0, 1'b0, 1'b0, 32'h0000_0108, 32'd0, 4'h0, 2, 32'h8888_8888, 1'b0);

    // Reset in the middle of an access.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0300;
    cyc();
    chk("mid_valid_before", {31'd0, bus.mem_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("mid_rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    bus.i_req = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_no_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("mid_rst_sb_empty", 32'(sb_q.size()), 32'd0);

    // After reset the tie goes to fetch again (last grant was data).
    bus.d_re = 1'b1; bus.d_addr = 32'h0000_3008; bus.d_be = 4'hF;
    run_xact(1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'd0, 4'h0, 0, 32'h9999_9999, 1'b0);
    run_xact(1'b1, 1'b1, 1'b0, 32'h0000_3008, 32'd0, 4'hF, 0, 32'hAAAA_AAAA, 1'b0);

    cyc(); cyc();
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("end_stall_idle", {31'd0, bus.stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
